// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: a write to FF46 copies LEN bytes from {page,8'h00} into OAM at one byte per STEP_CYCLES clocks.
// Optional build macro OAM_DMA_ECHO_MAP_EN folds echo pages E0..FF onto work RAM C0..DF.
module oam_dma_ctrl #(
   parameter int LEN         = 160,
   parameter int START_DELAY = 2,
   parameter int STEP_CYCLES = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_reg_write,
   input  logic [7:0]  i_d_wr,
   output logic [7:0]  o_reg_d_rd,
   output logic [15:0] o_src_addr,
   output logic        o_src_rd,
   input  logic [7:0]  i_src_data,
   output logic [7:0]  o_oam_addr,
   output logic [7:0]  o_oam_d_wr,
   output logic        o_oam_write,
   output logic        o_active,
   output logic        o_cpu_bus_block
);
   typedef enum logic [2:0] {S_IDLE, S_DELAY, S_READ, S_LATCH, S_WRITE, S_HOLD} state_t;

   localparam int CMAX = (START_DELAY > STEP_CYCLES) ? START_DELAY : STEP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [7:0]    LAST     = 8'(LEN - 1);
   localparam logic [CW-1:0] DLY_END  = CW'(START_DELAY - 1);
   localparam logic [CW-1:0] STEP_END = CW'(STEP_CYCLES - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_idx;
   logic [7:0]    r_page;
   logic [7:0]    r_reg_d_rd;
   logic [15:0]   r_src_addr;
   logic [7:0]    r_oam_addr;
   logic [7:0]    r_oam_d_wr;
   logic [7:0]    w_idx_nxt;

   function automatic logic [7:0] map_page(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_MAP_EN
      return (p[7:5] == 3'b111) ? p - 8'h20 : p;
`else
      return p;
`endif
   endfunction

   assign w_idx_nxt = r_idx + 8'd1;

   // Source address is loaded on entry to READ so it is valid during the strobe and holds afterwards.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= 8'h00;
         r_page     <= 8'h00;
         r_reg_d_rd <= 8'h00;
         r_src_addr <= 16'h0000;
         r_oam_addr <= 8'h00;
         r_oam_d_wr <= 8'h00;
      end else if (i_reg_write) begin
         r_page     <= i_d_wr;
         r_reg_d_rd <= i_d_wr;
         r_idx      <= 8'h00;
         r_cnt      <= '0;
         r_state    <= S_DELAY;
      end else begin
         unique case (r_state)
            S_IDLE: ;
            S_DELAY: begin
               if (r_cnt == DLY_END) begin
                  r_cnt      <= '0;
                  r_src_addr <= {map_page(r_page), r_idx};
                  r_state    <= S_READ;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_READ: begin
               r_cnt   <= r_cnt + 1'b1;
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_cnt      <= r_cnt + 1'b1;
               r_oam_addr <= r_idx;
               r_oam_d_wr <= i_src_data;
               r_state    <= S_WRITE;
            end
            S_WRITE, S_HOLD: begin
               if (r_cnt == STEP_END) begin
                  r_cnt <= '0;
                  if (r_idx == LAST) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_idx      <= w_idx_nxt;
                     r_src_addr <= {map_page(r_page), w_idx_nxt};
                     r_state    <= S_READ;
                  end
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= S_HOLD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A restart accepted in the WRITE clock abandons that byte.
   assign o_src_rd        = (r_state == S_READ);
   assign o_oam_write     = (r_state == S_WRITE) && !i_reg_write;
   assign o_active        = (r_state != S_IDLE);
   assign o_cpu_bus_block = o_active;
   assign o_reg_d_rd      = r_reg_d_rd;
   assign o_src_addr      = r_src_addr;
   assign o_oam_addr      = r_oam_addr;
   assign o_oam_d_wr      = r_oam_d_wr;
endmodule
